// File: rtl/lcd_cmd_ctrl.sv
// HD44780 character-LCD sequencer: runs the power-up init sequence, then forwards
// handshaked byte writes with setup / enable / hold / execution-wait timing in i_clk cycles.
module lcd_cmd_ctrl #(
  parameter int CNT_W   = 20,
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 23,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  // state   | meaning
  // PWRUP   | waiting for the LCD supply to settle after reset
  // SETUP   | RS/data driven, EN still low
  // EN_HI   | EN pulse high
  // HOLD    | EN low again, RS/data held
  // WAIT    | LCD executing the command
  // IDLE    | ready for a core write
  typedef enum logic [2:0] {
    S_PWRUP, S_SETUP, S_EN_HI, S_HOLD, S_WAIT, S_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(T_CLEAR - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       init_idx;
  logic             cnt_zero;
  logic             long_wait;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  assign cnt_zero  = (cnt == '0);
  // clear and return-home need the long execution wait
  assign long_wait = !o_lcd_rs && (o_lcd_data == 8'h01 || o_lcd_data == 8'h02 ||
                                   o_lcd_data == 8'h03);
  assign o_lcd_rw  = 1'b0;
  assign o_lcd_on  = 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_PWRUP;
      cnt         <= LD_PWRUP;
      init_idx    <= 2'd0;
      o_ready     <= 1'b0;
      o_init_done <= 1'b0;
      o_lcd_data  <= 8'h00;
      o_lcd_rs    <= 1'b0;
      o_lcd_en    <= 1'b0;
    end else begin
      case (state)
        S_PWRUP: begin
          if (cnt_zero) begin
            state      <= S_SETUP;
            cnt        <= LD_SETUP;
            init_idx   <= 2'd0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= init_cmd(2'd0);
          end else cnt <= cnt - 1'b1;
        end
        S_SETUP: begin
          if (cnt_zero) begin
            state    <= S_EN_HI;
            cnt      <= LD_EN;
            o_lcd_en <= 1'b1;
          end else cnt <= cnt - 1'b1;
        end
        S_EN_HI: begin
          if (cnt_zero) begin
            state    <= S_HOLD;
            cnt      <= LD_HOLD;
            o_lcd_en <= 1'b0;
          end else cnt <= cnt - 1'b1;
        end
        S_HOLD: begin
          if (cnt_zero) begin
            state <= S_WAIT;
            cnt   <= long_wait ? LD_CLEAR : LD_EXEC;
          end else cnt <= cnt - 1'b1;
        end
        S_WAIT: begin
          if (cnt_zero) begin
            if (!o_init_done && init_idx != 2'd3) begin
              state      <= S_SETUP;
              cnt        <= LD_SETUP;
              init_idx   <= init_idx + 2'd1;
              o_lcd_rs   <= 1'b0;
              o_lcd_data <= init_cmd(init_idx + 2'd1);
            end else begin
              state       <= S_IDLE;
              o_ready     <= 1'b1;
              o_init_done <= 1'b1;
            end
          end else cnt <= cnt - 1'b1;
        end
        S_IDLE: begin
          if (i_valid && o_ready) begin
            state      <= S_SETUP;
            cnt        <= LD_SETUP;
            o_ready    <= 1'b0;
            o_lcd_rs   <= i_rs;
            o_lcd_data <= i_data;
          end
        end
        default: begin
          state   <= S_PWRUP;
          cnt     <= LD_PWRUP;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Self-checking bench for lcd_cmd_ctrl: a transaction-level timing model is compared
// against the DUT every cycle, plus literal checks of init order, pulse widths and latencies.
module tb_lcd_cmd_ctrl;
  localparam int TP = 10, TS = 1, TE = 3, TH = 1, TX = 5, TC = 20;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_rs = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready, o_init_done, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
  logic [7:0] o_lcd_data;

  int tests = 0;
  int fails = 0;

  lcd_cmd_ctrl #(
    .CNT_W(20), .T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_CLEAR(TC)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_rs(i_rs), .i_data(i_data),
    .o_ready(o_ready), .o_init_done(o_init_done), .o_lcd_data(o_lcd_data),
    .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: each byte is a transfer starting at edge s lasting
  // TS+TE+TH+wait cycles; EN covers [s+TS, s+TS+TE) and the block is free from s+N.
  logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int         e = 0, t_start = 0, t_n = 0, init_i = 0;
  bit         have_tx = 0, m_done = 0, m_ready = 0, m_en = 0;
  logic       m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? TC : TX;
  endfunction

  initial forever begin
    @(posedge i_clk or negedge i_rst_n);
    if (!i_rst_n) begin
      e = 0; have_tx = 0; m_done = 0; m_ready = 0; m_en = 0; init_i = 0;
      m_rs = 1'b0; m_data = 8'h00;
    end else begin
      bit         go;
      logic       srs;
      logic [7:0] sd;
      go = 0; srs = 1'b0; sd = 8'h00;
      e++;
      if (!have_tx && !m_done && init_i == 0 && e == TP) begin
        go = 1; sd = init_cmds[0]; init_i = 1;
      end else if (have_tx && e == t_start + t_n) begin
        have_tx = 0;
        if (!m_done) begin
          if (init_i < 4) begin
            go = 1; sd = init_cmds[init_i]; init_i++;
          end else m_done = 1;
        end
      end else if (m_ready && i_valid) begin
        go = 1; srs = i_rs; sd = i_data;
      end
      if (go) begin
        have_tx = 1; t_start = e; t_n = TS + TE + TH + wait_len(srs, sd);
        m_rs = srs; m_data = sd;
      end
      m_en    = have_tx && e >= t_start + TS && e < t_start + TS + TE;
      m_ready = m_done && !have_tx;
    end
  end

  // Per-cycle comparison plus an EN-pulse log taken from the pins.
  logic [7:0] q_data [$];
  logic       q_rs [$];
  int         q_cyc [$];
  int         q_w [$];
  int         ncyc = 0, wcnt = 0;
  logic       prev_en = 1'b0;

  initial forever begin
    @(negedge i_clk);
    ncyc++;
    chk("en", int'(o_lcd_en), int'(m_en));
    chk("ready", int'(o_ready), int'(m_ready));
    chk("init_done", int'(o_init_done), int'(m_done));
    chk("lcd_rs", int'(o_lcd_rs), int'(m_rs));
    chk("lcd_data", int'(o_lcd_data), int'(m_data));
    chk("lcd_rw", int'(o_lcd_rw), 0);
    chk("lcd_on", int'(o_lcd_on), 1);
    if (o_lcd_en && !prev_en) begin
      q_data.push_back(o_lcd_data); q_rs.push_back(o_lcd_rs); q_cyc.push_back(ncyc);
      wcnt = 0;
    end
    if (o_lcd_en) wcnt++;
    if (!o_lcd_en && prev_en) q_w.push_back(wcnt);
    prev_en = o_lcd_en;
  end

  task automatic clear_log();
    q_data.delete(); q_rs.delete(); q_cyc.delete(); q_w.delete();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!o_ready && n < 200) begin @(negedge i_clk); n++; end
    if (!o_ready) chk({name, "_timeout"}, 0, 1);
  endtask

  // Count negedges from release until o_init_done; n equals the edge number.
  task automatic init_run(input string name, input bit poke);
    int n;
    n = 0;
    while (!o_init_done && n < 200) begin
      @(negedge i_clk); n++;
      if (poke) begin
        i_valid = 1'($urandom_range(0, 1)); i_rs = 1'($urandom_range(0, 1));
        i_data = 8'($urandom_range(0, 255));
      end
    end
    i_valid = 1'b0;
    chk({name, "_done_edge"}, n, 65);
    chk({name, "_ready"}, int'(o_ready), 1);
    chk({name, "_pulses"}, q_data.size(), 4);
    if (q_data.size() == 4 && q_w.size() == 4) begin
      chk({name, "_cmd0"}, int'(q_data[0]), 8'h38);
      chk({name, "_cmd1"}, int'(q_data[1]), 8'h0C);
      chk({name, "_cmd2"}, int'(q_data[2]), 8'h01);
      chk({name, "_cmd3"}, int'(q_data[3]), 8'h06);
      for (int i = 0; i < 4; i++) begin
        chk({name, "_rs"}, int'(q_rs[i]), 0);
        chk({name, "_width"}, q_w[i], 3);
      end
    end
  endtask

  // Called at a negedge with o_ready high; returns cycles until ready returns.
  task automatic do_write(input logic rs, input logic [7:0] d, output int lat);
    i_valid = 1'b1; i_rs = rs; i_data = d;
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 0;
    while (!o_ready && lat < 200) begin @(negedge i_clk); lat++; end
  endtask

  initial begin
    int lat;
    int n;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_done", int'(o_init_done), 0);
    chk("rst_en", int'(o_lcd_en), 0);
    chk("rst_data", int'(o_lcd_data), 0);
    chk("rst_on", int'(o_lcd_on), 1);

    clear_log();
    i_rst_n = 1'b1;
    init_run("init1", 1'b1);

    clear_log();
    do_write(1'b1, 8'h41, lat);
    chk("lat_41", lat, 10);
    if (q_data.size() == 1) begin
      chk("data_41", int'(q_data[0]), 8'h41);
      chk("rs_41", int'(q_rs[0]), 1);
    end else chk("pulses_41", q_data.size(), 1);
    do_write(1'b0, 8'h01, lat);
    chk("lat_clear", lat, 25);
    do_write(1'b1, 8'h01, lat);
    chk("lat_char01", lat, 10);

    // back-to-back: data changes while busy, only accept-edge values land
    clear_log();
    i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h48;
    repeat (3) @(negedge i_clk);
    i_data = 8'h49;
    n = 0;
    while (q_data.size() < 3 && n < 100) begin @(negedge i_clk); n++; end
    i_valid = 1'b0;
    chk("b2b_pulses", q_data.size(), 3);
    if (q_data.size() >= 3) begin
      chk("b2b_d0", int'(q_data[0]), 8'h48);
      chk("b2b_d1", int'(q_data[1]), 8'h49);
      chk("b2b_gap0", q_cyc[1] - q_cyc[0], 11);
      chk("b2b_gap1", q_cyc[2] - q_cyc[1], 11);
    end
    wait_ready("b2b");

    // random traffic, biased towards the long-wait command codes
    for (int i = 0; i < 600; i++) begin
      @(negedge i_clk);
      i_valid = ($urandom_range(0, 3) == 0);
      i_rs    = 1'($urandom_range(0, 1));
      i_data  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    wait_ready("rand");

    // reset during a user EN pulse
    i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h55;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("pre_rst_en", int'(o_lcd_en), 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_en", int'(o_lcd_en), 0);
    chk("async_ready", int'(o_ready), 0);
    chk("async_done", int'(o_init_done), 0);
    repeat (2) @(negedge i_clk);
    clear_log();
    i_rst_n = 1'b1;
    init_run("init2", 1'b0);
    repeat (3) @(negedge i_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/lcd_cmd_ctrl.md
# lcd_cmd_ctrl

HD44780-compatible character-LCD command sequencer that sits directly downstream of the RV32I core's LCD I/O output. It runs the power-up initialisation sequence on its own. It then accepts byte writes from the core-side I/O logic through a valid/ready handshake and drives the LCD pins with correct setup, enable-pulse, hold and execution-wait timing. All timing is expressed in i_clk cycles, so the block is clock-frequency agnostic.

## Interface
Parameters:
- CNT_W, 20: width of the internal delay counter; every timing parameter must be < 2^CNT_W.
- T_PWRUP, 750000: cycles to wait after reset release before the first init command (15 ms at 50 MHz).
- T_SETUP, 2: cycles RS/data are stable before EN rises.
- T_EN, 23: cycles EN is held high.
- T_HOLD, 2: cycles RS/data are held after EN falls.
- T_EXEC, 2000: post-command wait for normal commands and data (40 us).
- T_CLEAR, 82000: post-command wait for clear (0x01) and return-home (0x02, 0x03) commands (1.64 ms).

Ports:
- i_clk  in  1  clock, rising-edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  write request.
- i_rs  in  1  0 = command, 1 = character data.
- i_data  in  8  byte to write.
- o_ready  out  1  block can accept a write this cycle.
- o_init_done  out  1  power-up init sequence has completed.
- o_lcd_data  out  8  LCD DB[7:0].
- o_lcd_rs  out  1  LCD RS.
- o_lcd_rw  out  1  LCD RW, always 0 (write-only).
- o_lcd_en  out  1  LCD E.
- o_lcd_on  out  1  LCD power/backlight enable.

## Operation
- States: PWRUP, SETUP, EN_HI, HOLD, WAIT, IDLE.
- Each timed state lasts exactly its parameter count in cycles.
  - All timing parameters are ≥ 1.
  - The counter loads value−1 on state entry and advances on reaching 0.
- Reset (async): state = PWRUP; o_ready 0, o_init_done 0, o_lcd_en 0, o_lcd_rs 0, o_lcd_rw 0, o_lcd_data 0x00, o_lcd_on 1.
- PWRUP → SETUP after T_PWRUP cycles, loading the first init command.
- Init sequence, all with RS = 0, in this order:
  - 0x38: function set, 8-bit, 2 lines.
  - 0x0C: display on, cursor off.
  - 0x01: clear.
  - 0x06: entry mode, increment.
- Command flow: SETUP → EN_HI → HOLD → WAIT.
  - WAIT length is T_CLEAR if RS = 0 and data ∈ {0x01, 0x02, 0x03}, otherwise T_EXEC.
  - At the end of WAIT, the next init command loads directly into SETUP (no gap cycle).
  - After the last init command, WAIT → IDLE.
- o_init_done rises on the first entry to IDLE and stays high until reset.
- IDLE: o_ready = 1.
  - On a rising edge with i_valid & o_ready, latch i_rs/i_data into the output registers and go to SETUP.
  - o_ready is low from that edge onward.
- o_ready is 0 in every state except IDLE. i_valid outside IDLE is ignored, not queued.
- o_lcd_rs and o_lcd_data change only on transfer or init-command load, and hold their value through IDLE.
- o_lcd_en = 1 only in EN_HI. It is registered and glitch-free.
- User writes use the same T_CLEAR rule as init commands.

## Timing
- Let N = T_SETUP + T_EN + T_HOLD + T_WAIT, where T_WAIT is the selected wait.
- Write accepted at edge k:
  - o_lcd_rs/o_lcd_data valid after edge k.
  - o_lcd_en high after edge k+T_SETUP, low after edge k+T_SETUP+T_EN.
  - o_ready high again after edge k+N.
  - The earliest next accept is edge k+N+1.
- Throughput: one byte per N+1 cycles under back-to-back i_valid.
- Init duration: o_init_done rises after edge T_PWRUP + 3·(T_SETUP+T_EN+T_HOLD+T_EXEC) + (T_SETUP+T_EN+T_HOLD+T_CLEAR), counting edge 1 as the first edge with i_rst_n high.
- Reset mid-operation (including during EN_HI): o_lcd_en drops immediately (async), and the full init sequence reruns.
- RS/data never change while o_lcd_en = 1 or during HOLD.

## Test plan
Bench parameters for all scenarios: T_PWRUP=10, T_SETUP=1, T_EN=3, T_HOLD=1, T_EXEC=5, T_CLEAR=20.

- Reset release, no input:
  - EN pulses carry data 0x38, 0x0C, 0x01, 0x06 with RS = 0.
  - Each EN pulse is 3 cycles wide.
  - o_init_done and o_ready rise after edge 65; o_lcd_rw stays 0 throughout.
- After init, write RS=1 data=0x41 at edge k:
  - o_lcd_rs = 1 and o_lcd_data = 0x41 after edge k.
  - EN is high over edges k+1 to k+4.
  - o_ready is high again after edge k+10.
- Write RS=0 data=0x01 → o_ready returns after 25 cycles. Write RS=1 data=0x01 → o_ready returns after 10 cycles.
- i_valid held high with data 0x48 then 0x49 changed mid-busy:
  - Exactly one write per 11 cycles.
  - The byte latched is the one present on the accept edge.
  - No write occurs during busy.
- Assert i_rst_n low during EN_HI of a user write:
  - o_lcd_en, o_ready and o_init_done are 0 immediately.
  - After release, the init sequence repeats and o_init_done rises after edge 65.
- i_valid pulses during PWRUP and init → ignored; first user EN pulse only after o_init_done.
